// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction
// over a req/valid handshake and holds the split fields until execute is done.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [15:0] InstAddr,
    output logic        InstReq,
    input  logic [15:0] InstData,
    input  logic        InstValid,
    output logic [4:0]  OPCODE,
    output logic        flagbit,
    output logic [9:0]  IMM,
    output logic        IRValid,
    input  logic        ExecDone,
    input  logic        PCWrite,
    input  logic [15:0] PCTarget,
    output logic [15:0] PCPlus1,
    output logic        FetchErr
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        EXEC,
        HALT
    } stateT;

    localparam logic [7:0] WaitLimit = 8'(MAX_WAIT);

    stateT       state;
    stateT       stateNext;
    logic [15:0] pc;
    logic [15:0] pcNext;
    logic [15:0] ir;
    logic [7:0]  waitCnt;
    logic [7:0]  waitCntNext;
    logic        irLoad;
    logic        errSet;

    assign InstAddr = pc;
    assign PCPlus1  = pc + 16'd1;
    assign OPCODE   = ir[15:11];
    assign flagbit  = ir[10];
    assign IMM      = ir[9:0];
    assign IRValid  = (state == EXEC);

    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        waitCntNext = waitCnt;
        irLoad      = 1'b0;
        errSet      = 1'b0;
        unique case (state)
            // FETCH lingers one cycle after reset so the strobe can rise
            FETCH: begin
                waitCntNext = '0;
                if (InstReq) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (InstValid) begin
                    irLoad    = 1'b1;
                    stateNext = EXEC;
                end else begin
                    waitCntNext = waitCnt + 8'd1;
                    if (waitCntNext == WaitLimit) begin
                        errSet    = 1'b1;
                        stateNext = HALT;
                    end
                end
            end
            EXEC: begin
                if (ExecDone) begin
                    pcNext    = PCWrite ? PCTarget : PCPlus1;
                    stateNext = FETCH;
                end
            end
            HALT: begin
                stateNext = HALT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            waitCnt  <= '0;
            InstReq  <= 1'b0;
            FetchErr <= 1'b0;
        end else begin
            state   <= stateNext;
            pc      <= pcNext;
            waitCnt <= waitCntNext;
            InstReq <= (stateNext == FETCH);
            if (irLoad) begin
                ir <= InstData;
            end
            if (errSet) begin
                FetchErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: procedural reference model compared each cycle
// plus hand-computed checkpoints along a directed stimulus sequence.
module tb_instr_fetch_unit;

    localparam logic [15:0] RstPc   = 16'h0000;
    localparam int          MaxWait = 15;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] InstAddr;
    logic        InstReq;
    logic [15:0] InstData = 16'h0000;
    logic        InstValid = 1'b0;
    logic [4:0]  OPCODE;
    logic        flagbit;
    logic [9:0]  IMM;
    logic        IRValid;
    logic        ExecDone = 1'b0;
    logic        PCWrite = 1'b0;
    logic [15:0] PCTarget = 16'h0000;
    logic [15:0] PCPlus1;
    logic        FetchErr;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(
        .RESET_PC(RstPc),
        .MAX_WAIT(MaxWait)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .InstAddr (InstAddr),
        .InstReq  (InstReq),
        .InstData (InstData),
        .InstValid(InstValid),
        .OPCODE   (OPCODE),
        .flagbit  (flagbit),
        .IMM      (IMM),
        .IRValid  (IRValid),
        .ExecDone (ExecDone),
        .PCWrite  (PCWrite),
        .PCTarget (PCTarget),
        .PCPlus1  (PCPlus1),
        .FetchErr (FetchErr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: expected outputs for the cycle following each edge
    logic [15:0] expPc = RstPc;
    logic [15:0] expIr = 16'h0000;
    logic        expReq = 1'b0;
    logic        expIrV = 1'b0;
    logic        expErr = 1'b0;
    bit          chkOn = 1'b0;

    logic        sValid;
    logic        sDone;
    logic        sWrite;
    logic [15:0] sData;
    logic [15:0] sTarget;

    task automatic clk1(output bit r);
        @(posedge CLK);
        r       = Reset;
        sValid  = InstValid;
        sDone   = ExecDone;
        sWrite  = PCWrite;
        sData   = InstData;
        sTarget = PCTarget;
        if (r) begin
            expPc  = RstPc;
            expIr  = 16'h0000;
            expReq = 1'b0;
            expIrV = 1'b0;
            expErr = 1'b0;
        end
    endtask

    // One life of the unit between reset edges, written as a program
    task automatic lifeCycle();
        bit r;
        int waited;
        clk1(r);
        if (r) return;
        forever begin
            expReq = 1'b1;
            clk1(r);
            if (r) return;
            expReq = 1'b0;
            waited = 0;
            forever begin
                clk1(r);
                if (r) return;
                if (sValid) break;
                waited++;
                if (waited == MaxWait) begin
                    expErr = 1'b1;
                    forever begin
                        clk1(r);
                        if (r) return;
                    end
                end
            end
            expIr  = sData;
            expIrV = 1'b1;
            forever begin
                clk1(r);
                if (r) return;
                if (sDone) break;
            end
            expIrV = 1'b0;
            expPc  = sWrite ? sTarget : expPc + 16'd1;
        end
    endtask

    initial begin : model
        bit r;
        r = 1'b0;
        while (!r) clk1(r);
        chkOn = 1'b1;
        forever lifeCycle();
    end

    always @(negedge CLK) begin
        if (chkOn) begin
            chk("m_InstReq", 16'(InstReq), 16'(expReq));
            chk("m_IRValid", 16'(IRValid), 16'(expIrV));
            chk("m_FetchErr", 16'(FetchErr), 16'(expErr));
            chk("m_InstAddr", InstAddr, expPc);
            chk("m_PCPlus1", PCPlus1, expPc + 16'd1);
            chk("m_OPCODE", 16'(OPCODE), 16'(expIr[15:11]));
            chk("m_flagbit", 16'(flagbit), 16'(expIr[10]));
            chk("m_IMM", 16'(IMM), 16'(expIr[9:0]));
        end
    end

    // Called at the negedge of a request cycle; valid in wait cycle lat
    task automatic fetch(input logic [15:0] d, input int lat);
        for (int i = 1; i <= lat; i++) begin
            @(negedge CLK);
            if (i == lat) begin
                InstValid = 1'b1;
                InstData  = d;
            end
        end
        @(negedge CLK);
        InstValid = 1'b0;
        InstData  = 16'h0000;
    endtask

    task automatic execute(input int hold, input logic w,
                           input logic [15:0] t);
        repeat (hold) @(negedge CLK);
        ExecDone = 1'b1;
        PCWrite  = w;
        PCTarget = t;
        @(negedge CLK);
        ExecDone = 1'b0;
        PCWrite  = 1'b0;
        PCTarget = 16'h0000;
    endtask

    initial begin : stim
        repeat (2) @(negedge CLK);
        chk("rst_InstReq", 16'(InstReq), 16'h0);
        chk("rst_IRValid", 16'(IRValid), 16'h0);
        chk("rst_OPCODE", 16'(OPCODE), 16'h0);
        chk("rst_FetchErr", 16'(FetchErr), 16'h0);
        chk("rst_InstAddr", InstAddr, 16'h0000);
        Reset = 1'b0;
        @(negedge CLK);
        chk("first_req", 16'(InstReq), 16'h1);
        chk("first_addr", InstAddr, 16'h0000);

        fetch(16'h0C05, 1);
        chk("lat1_opcode", 16'(OPCODE), 16'h0001);
        chk("lat1_flagbit", 16'(flagbit), 16'h1);
        chk("lat1_imm", 16'(IMM), 16'h0005);
        chk("lat1_irvalid", 16'(IRValid), 16'h1);
        chk("lat1_plus1", PCPlus1, 16'h0001);
        execute(0, 1'b0, 16'h0BAD);
        chk("seq_req", 16'(InstReq), 16'h1);
        chk("seq_addr", InstAddr, 16'h0001);

        fetch(16'h3C00, 2);
        chk("jimm_opcode", 16'(OPCODE), 16'h0007);
        chk("jimm_plus1", PCPlus1, 16'h0002);
        execute(1, 1'b1, 16'h0123);
        chk("jump_addr", InstAddr, 16'h0123);

        fetch(16'h1234, 1);
        execute(0, 1'b1, 16'hFFFF);
        chk("wrap_addr", InstAddr, 16'hFFFF);
        chk("wrap_plus1", PCPlus1, 16'h0000);
        fetch(16'h0000, 3);
        execute(0, 1'b0, 16'h0000);
        chk("wrap_next", InstAddr, 16'h0000);

        @(negedge CLK);
        ExecDone = 1'b1;
        PCWrite  = 1'b1;
        PCTarget = 16'h5555;
        @(negedge CLK);
        ExecDone  = 1'b0;
        PCWrite   = 1'b0;
        PCTarget  = 16'h0000;
        InstValid = 1'b1;
        InstData  = 16'hF803;
        @(negedge CLK);
        InstData = 16'hFFFF;
        @(negedge CLK);
        InstValid = 1'b0;
        InstData  = 16'h0000;
        chk("noise_opcode", 16'(OPCODE), 16'h001F);
        chk("noise_imm", 16'(IMM), 16'h0003);
        execute(0, 1'b0, 16'h0000);
        chk("noise_addr", InstAddr, 16'h0001);

        fetch(16'hABCD, MaxWait);
        chk("late_err", 16'(FetchErr), 16'h0);
        chk("late_irvalid", 16'(IRValid), 16'h1);
        chk("late_imm", 16'(IMM), 16'h03CD);
        execute(0, 1'b0, 16'h0000);
        chk("late_next", InstAddr, 16'h0002);

        repeat (MaxWait) @(negedge CLK);
        chk("to_before", 16'(FetchErr), 16'h0);
        @(negedge CLK);
        chk("to_err", 16'(FetchErr), 16'h1);
        InstValid = 1'b1;
        InstData  = 16'h1111;
        ExecDone  = 1'b1;
        repeat (4) @(negedge CLK);
        chk("halt_req", 16'(InstReq), 16'h0);
        chk("halt_irvalid", 16'(IRValid), 16'h0);
        chk("halt_addr", InstAddr, 16'h0002);
        chk("halt_imm", 16'(IMM), 16'h03CD);
        InstValid = 1'b0;
        InstData  = 16'h0000;
        ExecDone  = 1'b0;

        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        chk("clr_err", 16'(FetchErr), 16'h0);
        chk("clr_req", 16'(InstReq), 16'h1);
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        Reset     = 1'b0;
        InstValid = 1'b1;
        InstData  = 16'hFFFF;
        @(negedge CLK);
        InstValid = 1'b0;
        InstData  = 16'h0000;
        chk("stray_req", 16'(InstReq), 16'h1);
        chk("stray_addr", InstAddr, RstPc);
        chk("stray_irvalid", 16'(IRValid), 16'h0);
        chk("stray_opcode", 16'(OPCODE), 16'h0);
        chk("stray_imm", 16'(IMM), 16'h0);

        fetch(16'h2801, 1);
        chk("final_opcode", 16'(OPCODE), 16'h0005);
        execute(0, 1'b0, 16'h0000);
        chk("final_addr", InstAddr, 16'h0001);
        repeat (3) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
